pipeline_stall_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Turns three conditions into per-stage enable and flush controls: load-use hazard, taken branch/jump resolved in EX, and a data-memory access awaiting acknowledge.
- Sits beside the forwarding/hazard logic, which supplies `load_use_i`. Owns all multi-cycle stall timing.

---
 rtl/pipeline_stall_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline enable/flush sequencer for load-use, branch and dmem-wait stalls
// Optional performance counters are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int unsigned LD_STALL_CYC = 1,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_use_i,
  input  logic             br_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic             mem_err_o,
`ifdef STALL_PERF_CNT_EN
  output logic [CNT_W-1:0] ld_stall_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LD_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  localparam logic [2:0] ST_LAST = 3'(LD_STALL_CYC - 1);
  localparam logic [7:0] TMO_MAX = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [2:0] st_cnt_q, st_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic dmem_miss, ld_stall_evt;

  assign dmem_miss = dmem_req_i & ~dmem_ack_i;

  always_comb begin
    state_d      = state_q;
    st_cnt_d     = st_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    mem_err      = 1'b0;
    ld_stall_evt = 1'b0;

    case (state_q)
      RUN: begin
        if (dmem_miss) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mem_wb_flush = 1'b1;
          state_d      = MEM_WAIT;
          tmo_cnt_d    = 8'd1;
        end else if (br_taken_i) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use_i) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_flush  = 1'b1;
          ld_stall_evt = 1'b1;
          if (LD_STALL_CYC > 1) begin
            state_d  = LD_STALL;
            st_cnt_d = 3'd1;
          end
        end
      end
      LD_STALL: begin
        // EX holds the bubble we inserted, so a branch cannot be resolved here
        if (dmem_miss) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mem_wb_flush = 1'b1;
          state_d      = MEM_WAIT;
          st_cnt_d     = 3'd0;
          tmo_cnt_d    = 8'd1;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_flush  = 1'b1;
          ld_stall_evt = 1'b1;
          if (st_cnt_q == ST_LAST) begin
            state_d  = RUN;
            st_cnt_d = 3'd0;
          end else begin
            st_cnt_d = st_cnt_q + 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i || (tmo_cnt_q == TMO_MAX)) begin
          mem_err     = ~dmem_ack_i;
          if_id_flush = br_taken_i;
          id_ex_flush = br_taken_i;
          state_d     = RUN;
          tmo_cnt_d   = 8'd0;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mem_wb_flush = 1'b1;
          tmo_cnt_d    = tmo_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = RUN;
        st_cnt_d  = 3'd0;
        tmo_cnt_d = 8'd0;
      end
    endcase

    // Reset forces every register to hold a bubble, independent of the clock
    if (!rst_ni) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      {if_id_flush, id_ex_flush, mem_wb_flush}          = 3'b111;
      mem_err      = 1'b0;
      ld_stall_evt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      st_cnt_q  <= 3'd0;
      tmo_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      st_cnt_q  <= st_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign pc_en_o        = pc_en;
  assign if_id_en_o     = if_id_en;
  assign id_ex_en_o     = id_ex_en;
  assign ex_mem_en_o    = ex_mem_en;
  assign mem_wb_en_o    = mem_wb_en;
  assign if_id_flush_o  = if_id_flush;
  assign id_ex_flush_o  = id_ex_flush;
  assign mem_wb_flush_o = mem_wb_flush;
  assign mem_err_o      = mem_err;
  assign state_o        = state_q;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] ld_stall_cnt_q, ld_stall_cnt_d;
  logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: they stick at all-ones rather than wrap
  always_comb begin
    ld_stall_cnt_d  = ld_stall_cnt_q;
    mem_stall_cnt_d = mem_stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    if (ld_stall_evt && (ld_stall_cnt_q != '1)) begin
      ld_stall_cnt_d = ld_stall_cnt_q + 1'b1;
    end
    if ((state_q == MEM_WAIT) && (mem_stall_cnt_q != '1)) begin
      mem_stall_cnt_d = mem_stall_cnt_q + 1'b1;
    end
    if (rst_ni && if_id_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_stall_cnt_q  <= '0;
      mem_stall_cnt_q <= '0;
      flush_cnt_q     <= '0;
    end else begin
      ld_stall_cnt_q  <= ld_stall_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign ld_stall_cnt_o  = ld_stall_cnt_q;
  assign mem_stall_cnt_o = mem_stall_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  logic             unused_ld_evt;
  assign unused_cnt_w  = '0;
  assign unused_ld_evt = ld_stall_evt;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - randomized and directed checks of pipeline_stall_ctrl against a reference model
module tb_pipeline_stall_ctrl;

  localparam int TMO = 16;
  localparam logic [10:0] RST_VEC = 11'b00000_111_0_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu = 1'b0, br = 1'b0, rq = 1'b0, ak = 1'b0;

  logic pc_en [2], if_id_en [2], id_ex_en [2], ex_mem_en [2], mem_wb_en [2];
  logic if_id_fl [2], id_ex_fl [2], mem_wb_fl [2], mem_err [2];
  logic [1:0] st [2];
  logic [10:0] obs [2];
  logic [10:0] exp_v [2];
`ifdef STALL_PERF_CNT_EN
  logic [31:0] c_ld [2], c_mem [2], c_fl [2];
`endif

  int ldc [2] = '{1, 3};
  int ld_left [2];
  bit in_wait [2];
  int wcnt [2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.LD_STALL_CYC(1), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .load_use_i(lu), .br_taken_i(br),
    .dmem_req_i(rq), .dmem_ack_i(ak),
    .pc_en_o(pc_en[0]), .if_id_en_o(if_id_en[0]), .id_ex_en_o(id_ex_en[0]),
    .ex_mem_en_o(ex_mem_en[0]), .mem_wb_en_o(mem_wb_en[0]),
    .if_id_flush_o(if_id_fl[0]), .id_ex_flush_o(id_ex_fl[0]), .mem_wb_flush_o(mem_wb_fl[0]),
    .mem_err_o(mem_err[0]),
`ifdef STALL_PERF_CNT_EN
    .ld_stall_cnt_o(c_ld[0]), .mem_stall_cnt_o(c_mem[0]), .flush_cnt_o(c_fl[0]),
`endif
    .state_o(st[0]));

  pipeline_stall_ctrl #(.LD_STALL_CYC(3), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .load_use_i(lu), .br_taken_i(br),
    .dmem_req_i(rq), .dmem_ack_i(ak),
    .pc_en_o(pc_en[1]), .if_id_en_o(if_id_en[1]), .id_ex_en_o(id_ex_en[1]),
    .ex_mem_en_o(ex_mem_en[1]), .mem_wb_en_o(mem_wb_en[1]),
    .if_id_flush_o(if_id_fl[1]), .id_ex_flush_o(id_ex_fl[1]), .mem_wb_flush_o(mem_wb_fl[1]),
    .mem_err_o(mem_err[1]),
`ifdef STALL_PERF_CNT_EN
    .ld_stall_cnt_o(c_ld[1]), .mem_stall_cnt_o(c_mem[1]), .flush_cnt_o(c_fl[1]),
`endif
    .state_o(st[1]));

  assign obs[0] = {pc_en[0], if_id_en[0], id_ex_en[0], ex_mem_en[0], mem_wb_en[0],
                   if_id_fl[0], id_ex_fl[0], mem_wb_fl[0], mem_err[0], st[0]};
  assign obs[1] = {pc_en[1], if_id_en[1], id_ex_en[1], ex_mem_en[1], mem_wb_en[1],
                   if_id_fl[1], id_ex_fl[1], mem_wb_fl[1], mem_err[1], st[1]};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ld_left[i] = 0;
      in_wait[i] = 1'b0;
      wcnt[i]    = 0;
    end
  endtask

  // Expected outputs for this cycle, then advance the model to the next cycle
  task automatic model_eval(input int i);
    bit [4:0] en;
    bit [2:0] fl;
    bit er;
    bit [1:0] s;
    bit miss;
    miss = rq && !ak;
    en = 5'b11111; fl = 3'b000; er = 1'b0; s = 2'd0;
    if (!rst_n) begin
      exp_v[i] = RST_VEC;
      ld_left[i] = 0; in_wait[i] = 1'b0; wcnt[i] = 0;
      return;
    end
    if (in_wait[i]) begin
      s = 2'd2;
      if (ak || wcnt[i] == TMO) begin
        er = !ak;
        if (br) fl = 3'b110;
        in_wait[i] = 1'b0;
      end else begin
        en = 5'b00001; fl = 3'b001;
        wcnt[i]++;
      end
    end else if (ld_left[i] > 0) begin
      s = 2'd1;
      if (miss) begin
        en = 5'b00001; fl = 3'b001;
        in_wait[i] = 1'b1; wcnt[i] = 1; ld_left[i] = 0;
      end else begin
        en = 5'b00111; fl = 3'b010;
        ld_left[i]--;
      end
    end else begin
      if (miss) begin
        en = 5'b00001; fl = 3'b001;
        in_wait[i] = 1'b1; wcnt[i] = 1;
      end else if (br) begin
        fl = 3'b110;
      end else if (lu) begin
        en = 5'b00111; fl = 3'b010;
        ld_left[i] = ldc[i] - 1;
      end
    end
    exp_v[i] = {en, fl, er, s};
  endtask

  task automatic step(input bit r, input bit l, input bit b, input bit q, input bit a);
    @(posedge clk);
    #1;
    rst_n = r; lu = l; br = b; rq = q; ak = a;
    @(negedge clk);
    cyc++;
    model_eval(0);
    model_eval(1);
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      step(1'b0, n[0], 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k] || obs[k] !== RST_VEC) begin
          errors++;
          $display("FAIL test_reset dut%0d cyc%0d got=%b exp=%b", k, cyc, obs[k], RST_VEC);
        end
      end
    end
  endtask

  task automatic test_load_use();
    for (int n = 0; n < 6; n++) begin
      step(1'b1, n == 1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL test_load_use dut%0d cyc%0d got=%b exp=%b", k, cyc, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_branch_priority();
    for (int n = 0; n < 4; n++) begin
      step(1'b1, 1'b1, n < 2, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL test_branch_priority dut%0d cyc%0d got=%b exp=%b", k, cyc, obs[k], exp_v[k]);
        end
      end
    end
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mem_ack();
    for (int rep = 0; rep < 2; rep++) begin
      for (int n = 0; n < 8; n++) begin
        step(1'b1, n == 5, (n == 5) && (rep == 0), n <= 5, n == 5);
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obs[k] !== exp_v[k]) begin
            errors++;
            $display("FAIL test_mem_ack dut%0d cyc%0d got=%b exp=%b", k, cyc, obs[k], exp_v[k]);
          end
        end
      end
    end
    for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int pulses [2];
    pulses = '{0, 0};
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 1'b0, 1'b0, n <= 16, 1'b0);
      for (int k = 0; k < 2; k++) begin
        if (mem_err[k] === 1'b1) pulses[k]++;
        checks++;
        if (obs[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL test_timeout dut%0d cyc%0d got=%b exp=%b", k, cyc, obs[k], exp_v[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pulses[k] != 1) begin
        errors++;
        $display("FAIL test_timeout_pulses dut%0d got=%0d exp=1", k, pulses[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== RST_VEC) begin
        errors++;
        $display("FAIL test_mid_reset_async dut%0d got=%b exp=%b", k, obs[k], RST_VEC);
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (c_ld[k] !== 32'd0 || c_mem[k] !== 32'd0 || c_fl[k] !== 32'd0) begin
        errors++;
        $display("FAIL test_mid_reset_cnt dut%0d got=%0d/%0d/%0d exp=0", k, c_ld[k], c_mem[k], c_fl[k]);
      end
`endif
    end
    for (int n = 0; n < 4; n++) begin
      step(n > 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL test_mid_reset dut%0d cyc%0d got=%b exp=%b", k, cyc, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      step(($urandom % 300) != 0, ($urandom % 100) < 35, ($urandom % 100) < 25,
           ($urandom % 100) < 30, ($urandom % 100) < 40);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL test_random dut%0d cyc%0d got=%b exp=%b", k, cyc, obs[k], exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_ack();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
